// File: rtl/risc_v_pkg.sv
// Shared types for the risc_v_pipeline hazard logic: scoreboard entry layout
// and the forwarding-select encoding for "read the register file".
package risc_v_pkg;

    // Wide enough for any register file this core is built with.
    localparam int HZ_RD_W = 8;
    localparam int FWD_RF  = 0;

    typedef struct packed {
        logic               valid;
        logic               wen;
        logic               is_load;
        logic [HZ_RD_W-1:0] rd;
    } hz_entry_t;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// One source operand: finds the youngest in-flight producer of the register
// and flags a load whose data is not yet forwardable.
module hz_match
    import risc_v_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int REG_AW   = 5,
    parameter int FW       = 2
) (
    input  hz_entry_t [DEPTH:1] ent_i,
    input  logic [REG_AW-1:0]   rs_i,
    input  logic                used_i,
    output logic [FW-1:0]       sel_o,
    output logic                load_use_o
);

    logic [HZ_RD_W-1:0] rs_ext;
    logic               hit;

    assign rs_ext = HZ_RD_W'(rs_i);

    // Scan from the youngest stage; the first hit shadows all older ones.
    always_comb begin
        sel_o      = FW'(FWD_RF);
        load_use_o = 1'b0;
        hit        = 1'b0;
        for (int s = 1; s <= DEPTH; s++) begin
            if (!hit && used_i && ent_i[s].valid && ent_i[s].wen &&
                ent_i[s].rd != '0 && ent_i[s].rd == rs_ext) begin
                hit        = 1'b1;
                sel_o      = FW'(s);
                load_use_o = ent_i[s].is_load && (s <= LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller beside the ID stage: in-flight destination
// tracking, load-use stall, operand forwarding selects and redirect flush.
module hazard_scoreboard
    import risc_v_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int DEPTH        = 3,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32,
    localparam int REG_AW      = $clog2(NUM_REGS),
    localparam int FW          = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_reg_wen_i,
    input  logic              id_is_load_i,
    input  logic              redirect_i,
    output logic              stall_o,
    output logic              bubble_o,
    output logic              flush_o,
    output logic [FW-1:0]     fwd_a_sel_o,
    output logic [FW-1:0]     fwd_b_sel_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int FCW = $clog2(FLUSH_CYCLES + 1);

    hz_entry_t [DEPTH:1] ent_q, ent_d;
    logic [FCW-1:0]      flush_q, flush_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic                rdy_q;

    logic          id_vld, flushing, stall, accepted, redir_acc;
    logic [FW-1:0] sel_a, sel_b;
    logic          lu_a, lu_b;

    assign flushing = (flush_q != '0);
    assign id_vld   = id_valid_i & ~flushing;

    hz_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .REG_AW(REG_AW), .FW(FW)) u_match_a (
        .ent_i      (ent_q),
        .rs_i       (id_rs1_i),
        .used_i     (id_rs1_used_i & id_vld),
        .sel_o      (sel_a),
        .load_use_o (lu_a)
    );

    hz_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .REG_AW(REG_AW), .FW(FW)) u_match_b (
        .ent_i      (ent_q),
        .rs_i       (id_rs2_i),
        .used_i     (id_rs2_used_i & id_vld),
        .sel_o      (sel_b),
        .load_use_o (lu_b)
    );

    assign stall     = lu_a | lu_b;
    assign accepted  = id_vld & ~stall;
    // rdy_q keeps flush quiet during reset and the first cycle after it.
    assign redir_acc = redirect_i & ~stall & ~flushing & rdy_q;

    assign stall_o     = stall;
    assign bubble_o    = stall;
    assign flush_o     = redir_acc | flushing;
    assign fwd_a_sel_o = stall ? FW'(FWD_RF) : sel_a;
    assign fwd_b_sel_o = stall ? FW'(FWD_RF) : sel_b;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    always_comb begin
        ent_d = '0;
        if (accepted) begin
            ent_d[1].valid   = 1'b1;
            ent_d[1].wen     = id_reg_wen_i;
            ent_d[1].is_load = id_is_load_i;
            ent_d[1].rd      = HZ_RD_W'(id_rd_i);
        end
        for (int s = 2; s <= DEPTH; s++) begin
            ent_d[s] = ent_q[s-1];
        end
    end

    always_comb begin
        flush_d = flush_q;
        if (redir_acc)
            flush_d = FCW'(FLUSH_CYCLES - 1);
        else if (flushing)
            flush_d = flush_q - 1'b1;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (redir_acc && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q       <= '0;
            flush_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            rdy_q       <= 1'b0;
        end else begin
            ent_q       <= ent_d;
            flush_q     <= flush_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            rdy_q       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of hazard_scoreboard with DEPTH=3, LOAD_LAT=1, FLUSH_CYCLES=2.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i, id_rs1_used_i, id_rs2_used_i, id_reg_wen_i, id_is_load_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        redirect_i;
    logic        stall_o, bubble_o, flush_o;
    logic [1:0]  fwd_a_sel_o, fwd_b_sel_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    hazard_scoreboard #(
        .NUM_REGS(32), .DEPTH(3), .LOAD_LAT(1), .FLUSH_CYCLES(2), .CNT_W(32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .id_rd_i       (id_rd_i),
        .id_reg_wen_i  (id_reg_wen_i),
        .id_is_load_i  (id_is_load_i),
        .redirect_i    (redirect_i),
        .stall_o       (stall_o),
        .bubble_o      (bubble_o),
        .flush_o       (flush_o),
        .fwd_a_sel_o   (fwd_a_sel_o),
        .fwd_b_sel_o   (fwd_b_sel_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic id(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic wen, input logic ld);
        id_valid_i = v;  id_rs1_i = rs1; id_rs1_used_i = u1;
        id_rs2_i = rs2;  id_rs2_used_i = u2;
        id_rd_i = rd;    id_reg_wen_i = wen; id_is_load_i = ld;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        id(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        redirect_i = 1'b0;
        id(0, 0, 0, 0, 0, 0, 0, 0);
        #11;
        chk("rst_stall", stall_o, 0);
        chk("rst_cnt", stall_cnt_o, 0);
        redirect_i = 1'b1; #1;
        chk("rst_flush", flush_o, 0);
        rst = 1'b0; #1;
        chk("first_cycle_flush", flush_o, 0);
        redirect_i = 1'b0;
        step();

        // load-use: lw x5 then add x6,x5,x1
        id(1, 1, 1, 0, 0, 5, 1, 1);
        chk("lw_nostall", stall_o, 0);
        step();
        id(1, 5, 1, 1, 1, 6, 1, 0);
        chk("lu_stall", stall_o, 1);
        chk("lu_bubble", bubble_o, 1);
        chk("lu_sel_a", fwd_a_sel_o, 0);
        step();
        chk("lu_release", stall_o, 0);
        chk("lu_fwd_a", fwd_a_sel_o, 2);
        chk("lu_fwd_b", fwd_b_sel_o, 0);
        chk("lu_stall_cnt", stall_cnt_o, 1);
        step();
        idle(3);

        // ALU forwarding distance 1, 3, then out of window
        id(1, 1, 1, 2, 1, 5, 1, 0); step();
        id(1, 5, 1, 5, 1, 7, 1, 0);
        chk("d1_stall", stall_o, 0);
        chk("d1_a", fwd_a_sel_o, 1);
        chk("d1_b", fwd_b_sel_o, 1);
        step();
        id(1, 1, 1, 2, 1, 8, 1, 0); step();
        id(1, 5, 1, 5, 1, 10, 1, 0);
        chk("d3_a", fwd_a_sel_o, 3);
        chk("d3_b", fwd_b_sel_o, 3);
        step();
        id(1, 5, 1, 5, 1, 12, 1, 0);
        chk("d4_a", fwd_a_sel_o, 0);
        chk("d4_b", fwd_b_sel_o, 0);
        step();
        idle(3);

        // x0 never matches; unused operand never matches
        id(1, 1, 1, 2, 1, 0, 1, 0); step();
        id(1, 0, 1, 0, 1, 3, 1, 0);
        chk("x0_a", fwd_a_sel_o, 0);
        chk("x0_b", fwd_b_sel_o, 0);
        step();
        id(1, 1, 1, 2, 1, 11, 1, 0); step();
        id(1, 11, 0, 11, 1, 13, 1, 0);
        chk("unused_a", fwd_a_sel_o, 0);
        chk("used_b", fwd_b_sel_o, 1);
        step();
        idle(3);

        // youngest producer wins
        id(1, 1, 1, 2, 1, 5, 1, 0); step();
        id(1, 1, 1, 2, 1, 5, 1, 0); step();
        id(1, 5, 1, 0, 0, 14, 1, 0);
        chk("youngest_a", fwd_a_sel_o, 1);
        step();
        idle(3);

        // two-cycle flush from a one-cycle redirect
        id(1, 1, 1, 2, 1, 0, 0, 0);
        redirect_i = 1'b1; #1;
        chk("flush_c0", flush_o, 1);
        chk("flush_c0_stall", stall_o, 0);
        step();
        redirect_i = 1'b0;
        id(1, 3, 1, 4, 1, 9, 1, 0);
        chk("flush_c1", flush_o, 1);
        step();
        chk("flush_c2", flush_o, 0);
        chk("flush_cnt", flush_cnt_o, 1);
        idle(3);

        // redirect during a load-use stall is ignored
        id(1, 1, 1, 0, 0, 5, 1, 1); step();
        id(1, 5, 1, 1, 1, 6, 1, 0);
        redirect_i = 1'b1; #1;
        chk("ign_stall", stall_o, 1);
        chk("ign_flush", flush_o, 0);
        step();
        redirect_i = 1'b0; #1;
        chk("ign_flush_cnt", flush_cnt_o, 1);
        chk("ign_stall_cnt", stall_cnt_o, 2);
        idle(3);

        // reset in the middle of a stall
        id(1, 1, 1, 0, 0, 5, 1, 1); step();
        id(1, 5, 1, 1, 1, 6, 1, 0);
        chk("pre_rst_stall", stall_o, 1);
        rst = 1'b1; #1;
        chk("rst_drop_stall", stall_o, 0);
        chk("rst_drop_bubble", bubble_o, 0);
        step();
        rst = 1'b0; #1;
        chk("post_rst_stall", stall_o, 0);
        chk("post_rst_sel_a", fwd_a_sel_o, 0);
        chk("post_rst_stall_cnt", stall_cnt_o, 0);
        chk("post_rst_flush_cnt", flush_cnt_o, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
